// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: walks the PC, issues one imem request at a time and
// hands each returned word to the decoder, stopping for good after a HALT word.
// Latency: req cycle, >=1 memory cycle, then instr_valid; 3 cycles/instr minimum.
// Backpressure: stall holds instr/pc_out; no new request is issued until the
// held word is consumed.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   imem_req/imem_addr       one-cycle fetch request at pc
//   imem_rdata/imem_valid    memory response (one per request)
//   stall                    decoder not ready, hold current instr
//   redirect/redirect_pc     taken branch/jump target from execute
//   instr/instr_valid        registered instruction to decoder
//   pc_out/pc_inc            address of instr and that address + 2
//   halted                   HALT consumed, fetch stopped until rst
module instr_fetch_unit #(
   parameter int              PC_W     = 16,
   parameter int              INSTR_W  = 16,
   parameter logic [PC_W-1:0] RESET_PC = '0
) (
   input  logic               clk,
   input  logic               rst,
   output logic               imem_req,
   output logic [PC_W-1:0]    imem_addr,
   input  logic [INSTR_W-1:0] imem_rdata,
   input  logic               imem_valid,
   input  logic               stall,
   input  logic               redirect,
   input  logic [PC_W-1:0]    redirect_pc,
   output logic [INSTR_W-1:0] instr,
   output logic               instr_valid,
   output logic [PC_W-1:0]    pc_out,
   output logic [PC_W-1:0]    pc_inc,
   output logic               halted
);

   localparam logic [INSTR_W-1:0] NOP_INSTR = INSTR_W'(16'h0800);
   localparam logic [PC_W-1:0]    PC_STEP   = PC_W'(2);
   localparam logic [PC_W-1:0]    PC_MASK   = ~PC_W'(1);

   typedef enum logic [2:0] {
      S_FETCH,
      S_WAIT,
      S_HOLD,
      S_HALTING,
      S_HALTED
   } state_t;

   state_t             state, state_d;
   logic [PC_W-1:0]    pc, pc_d;
   logic [INSTR_W-1:0] instr_d;
   logic [PC_W-1:0]    pc_out_d;
   logic               valid_d;
   logic               halted_d;
   logic               drop_pending, drop_d;

   logic [PC_W-1:0]    redir_pc;
   logic               op_halt;

   // Targets are halfword aligned; the low bit from execute is ignored.
   assign redir_pc = redirect_pc & PC_MASK;
   assign op_halt  = (imem_rdata[INSTR_W-1 -: 5] == 5'b00000);

   // Gated with rst so that no request is visible while reset is held.
   assign imem_req  = (state == S_FETCH) && !rst;
   assign imem_addr = pc;
   assign pc_inc    = pc_out + PC_STEP;

   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= S_FETCH;
         pc           <= RESET_PC;
         instr        <= NOP_INSTR;
         instr_valid  <= 1'b0;
         pc_out       <= RESET_PC;
         halted       <= 1'b0;
         drop_pending <= 1'b0;
      end else begin
         state        <= state_d;
         pc           <= pc_d;
         instr        <= instr_d;
         instr_valid  <= valid_d;
         pc_out       <= pc_out_d;
         halted       <= halted_d;
         drop_pending <= drop_d;
      end
   end

   always_comb begin
      state_d  = state;
      pc_d     = pc;
      instr_d  = instr;
      pc_out_d = pc_out;
      valid_d  = instr_valid;
      halted_d = halted;
      drop_d   = drop_pending;

      case (state)
         S_FETCH: begin
            state_d = S_WAIT;
            // The request issued this cycle is already in flight: its
            // response must be thrown away when it arrives.
            if (redirect) begin
               pc_d    = redir_pc;
               valid_d = 1'b0;
               drop_d  = 1'b1;
            end
         end

         S_WAIT: begin
            if (redirect) begin
               pc_d    = redir_pc;
               valid_d = 1'b0;
               if (imem_valid) begin
                  // Response lands with the redirect: discard it now.
                  drop_d  = 1'b0;
                  state_d = S_FETCH;
               end else begin
                  drop_d  = 1'b1;
               end
            end else if (imem_valid) begin
               if (drop_pending) begin
                  drop_d  = 1'b0;
                  state_d = S_FETCH;
               end else begin
                  instr_d  = imem_rdata;
                  pc_out_d = pc;
                  pc_d     = pc + PC_STEP;
                  valid_d  = 1'b1;
                  state_d  = op_halt ? S_HALTING : S_HOLD;
               end
            end
         end

         S_HOLD, S_HALTING: begin
            if (redirect) begin
               // Held word is on the wrong path (including a HALT).
               pc_d    = redir_pc;
               valid_d = 1'b0;
               state_d = S_FETCH;
            end else if (!stall) begin
               valid_d = 1'b0;
               if (state == S_HALTING) begin
                  halted_d = 1'b1;
                  state_d  = S_HALTED;
               end else begin
                  state_d  = S_FETCH;
               end
            end
         end

         S_HALTED: begin
            state_d = S_HALTED;
         end

         default: begin
            state_d = S_FETCH;
         end
      endcase
   end

endmodule

// File: tb/tb_instr_fetch_unit.sv
module tb_instr_fetch_unit;

   typedef struct {
      logic [15:0] i;
      logic [15:0] p;
      logic [15:0] n;
   } exp_t;

   logic        clk;
   logic        rst;
   logic        imem_req;
   logic [15:0] imem_addr;
   logic [15:0] imem_rdata;
   logic        imem_valid;
   logic        stall;
   logic        redirect;
   logic [15:0] redirect_pc;
   logic [15:0] instr;
   logic        instr_valid;
   logic [15:0] pc_out;
   logic [15:0] pc_inc;
   logic        halted;

   logic        w_rst;
   logic        w_req;
   logic [15:0] w_addr;
   logic [15:0] w_rdata;
   logic        w_valid;
   logic [15:0] w_instr;
   logic        w_iv;
   logic [15:0] w_pc;
   logic [15:0] w_inc;
   logic        w_halted;

   int n_chk = 0;
   int n_fail = 0;
   int lat = 1;

   logic [15:0] aq[$];
   exp_t        iq[$];
   logic [15:0] waq[$];
   exp_t        wiq[$];

   instr_fetch_unit #(.PC_W(16), .INSTR_W(16), .RESET_PC(16'h0000)) dut (
      .clk(clk), .rst(rst),
      .imem_req(imem_req), .imem_addr(imem_addr),
      .imem_rdata(imem_rdata), .imem_valid(imem_valid),
      .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
      .instr(instr), .instr_valid(instr_valid),
      .pc_out(pc_out), .pc_inc(pc_inc), .halted(halted)
   );

   instr_fetch_unit #(.PC_W(16), .INSTR_W(16), .RESET_PC(16'hFFFE)) u_wrap (
      .clk(clk), .rst(w_rst),
      .imem_req(w_req), .imem_addr(w_addr),
      .imem_rdata(w_rdata), .imem_valid(w_valid),
      .stall(1'b0), .redirect(1'b0), .redirect_pc(16'h0000),
      .instr(w_instr), .instr_valid(w_iv),
      .pc_out(w_pc), .pc_inc(w_inc), .halted(w_halted)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic logic [15:0] mem(input logic [15:0] a);
      case (a)
         16'h0000: mem = 16'h4000;
         16'h0002: mem = 16'h4120;
         16'h0004: mem = 16'hA241;
         16'h0006: mem = 16'h0000;
         default:  mem = {5'b01000, a[10:0]};
      endcase
   endfunction

   function automatic exp_t mk(input logic [15:0] i, input logic [15:0] p,
                               input logic [15:0] n);
      exp_t e;
      e.i = i;
      e.p = p;
      e.n = n;
      return e;
   endfunction

   task automatic check(input string nm, input logic [15:0] act, input logic [15:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic fail_now(input string nm, input logic [15:0] act);
      n_chk++;
      n_fail++;
      $display("FAIL %s: got %h expected nothing", nm, act);
   endtask

   // Memory for the main instance: answers lat cycles after each request.
   initial begin
      int          cnt;
      logic [15:0] a;
      cnt = 0;
      a = '0;
      imem_valid = 1'b0;
      imem_rdata = '0;
      forever begin
         @(negedge clk);
         imem_valid = 1'b0;
         if (rst) begin
            cnt = 0;
         end else begin
            if (cnt > 0) begin
               cnt--;
               if (cnt == 0) begin
                  imem_valid = 1'b1;
                  imem_rdata = mem(a);
               end
            end
            if (imem_req) begin
               cnt = lat;
               a = imem_addr;
            end
         end
      end
   end

   // Memory for the wrap instance: fixed one-cycle latency.
   initial begin
      logic        pend;
      logic [15:0] a;
      pend = 1'b0;
      a = '0;
      w_valid = 1'b0;
      w_rdata = '0;
      forever begin
         @(negedge clk);
         w_valid = 1'b0;
         if (w_rst) begin
            pend = 1'b0;
         end else begin
            if (pend) begin
               w_valid = 1'b1;
               w_rdata = mem(a);
               pend = 1'b0;
            end
            if (w_req) begin
               pend = 1'b1;
               a = w_addr;
            end
         end
      end
   end

   // Monitor: every request address against the expected address queue.
   initial begin
      forever begin
         @(negedge clk);
         if (imem_req === 1'b1) begin
            if (aq.size() == 0) fail_now("unexpected_imem_req", imem_addr);
            else check("imem_addr", imem_addr, aq.pop_front());
         end
         if (w_req === 1'b1) begin
            if (waq.size() == 0) fail_now("unexpected_wrap_req", w_addr);
            else check("wrap_imem_addr", w_addr, waq.pop_front());
         end
      end
   end

   // Monitor: each new instruction against the expected queue; held
   // instructions must not change while instr_valid stays high.
   initial begin
      logic        prev, wprev;
      logic [15:0] hi, hp;
      exp_t        e;
      prev = 1'b0;
      wprev = 1'b0;
      hi = '0;
      hp = '0;
      forever begin
         @(negedge clk);
         if (instr_valid === 1'b1 && !prev) begin
            if (iq.size() == 0) begin
               fail_now("unexpected_instr", instr);
            end else begin
               e = iq.pop_front();
               check("instr", instr, e.i);
               check("pc_out", pc_out, e.p);
               check("pc_inc", pc_inc, e.n);
            end
            hi = instr;
            hp = pc_out;
         end else if (instr_valid === 1'b1) begin
            check("held_instr", instr, hi);
            check("held_pc_out", pc_out, hp);
         end
         prev = (instr_valid === 1'b1);

         if (w_iv === 1'b1 && !wprev) begin
            if (wiq.size() == 0) begin
               fail_now("unexpected_wrap_instr", w_instr);
            end else begin
               e = wiq.pop_front();
               check("wrap_instr", w_instr, e.i);
               check("wrap_pc_out", w_pc, e.p);
               check("wrap_pc_inc", w_inc, e.n);
            end
         end
         wprev = (w_iv === 1'b1);
      end
   end

   task automatic wait_pc_valid(input logic [15:0] p);
      logic hit;
      hit = 1'b0;
      for (int k = 0; k < 200 && !hit; k++) begin
         @(posedge clk); #1;
         if (instr_valid && pc_out == p) hit = 1'b1;
      end
      if (!hit) fail_now("timeout_instr_valid_pc", p);
   endtask

   task automatic wait_req(input logic [15:0] a);
      logic hit;
      hit = 1'b0;
      for (int k = 0; k < 200 && !hit; k++) begin
         @(posedge clk); #1;
         if (imem_req && imem_addr == a) hit = 1'b1;
      end
      if (!hit) fail_now("timeout_imem_req", a);
   endtask

   task automatic wait_main_empty();
      logic hit;
      hit = 1'b0;
      for (int k = 0; k < 200 && !hit; k++) begin
         @(posedge clk); #1;
         if (aq.size() == 0 && iq.size() == 0) hit = 1'b1;
      end
      if (!hit) fail_now("timeout_main_queue", 16'(iq.size()));
   endtask

   task automatic wait_wrap_empty();
      logic hit;
      hit = 1'b0;
      for (int k = 0; k < 200 && !hit; k++) begin
         @(posedge clk); #1;
         if (waq.size() == 0 && wiq.size() == 0) hit = 1'b1;
      end
      if (!hit) fail_now("timeout_wrap_queue", 16'(wiq.size()));
   endtask

   initial begin
      int reqs;
      rst = 1'b1;
      w_rst = 1'b1;
      stall = 1'b0;
      redirect = 1'b0;
      redirect_pc = '0;

      repeat (2) @(posedge clk);
      #1;
      check("rst_instr", instr, 16'h0800);
      check("rst_instr_valid", {15'd0, instr_valid}, 16'd0);
      check("rst_pc_out", pc_out, 16'h0000);
      check("rst_pc_inc", pc_inc, 16'h0002);
      check("rst_halted", {15'd0, halted}, 16'd0);
      check("rst_imem_req", {15'd0, imem_req}, 16'd0);
      check("wrap_rst_pc_out", w_pc, 16'hFFFE);
      check("wrap_rst_halted", {15'd0, w_halted}, 16'd0);

      // Basic stream, stall on the second word, then HALT at 0x0006.
      aq.push_back(16'h0000); aq.push_back(16'h0002);
      aq.push_back(16'h0004); aq.push_back(16'h0006);
      iq.push_back(mk(16'h4000, 16'h0000, 16'h0002));
      iq.push_back(mk(16'h4120, 16'h0002, 16'h0004));
      iq.push_back(mk(16'hA241, 16'h0004, 16'h0006));
      iq.push_back(mk(16'h0000, 16'h0006, 16'h0008));
      rst = 1'b0;

      wait_pc_valid(16'h0002);
      stall = 1'b1;
      repeat (4) begin
         check("stall_imem_req", {15'd0, imem_req}, 16'd0);
         check("stall_instr_valid", {15'd0, instr_valid}, 16'd1);
         @(posedge clk); #1;
      end
      stall = 1'b0;
      @(posedge clk); #1;
      check("post_stall_req", {15'd0, imem_req}, 16'd1);
      check("post_stall_addr", imem_addr, 16'h0004);

      wait_pc_valid(16'h0006);
      stall = 1'b1;
      repeat (2) begin
         check("halting_instr_valid", {15'd0, instr_valid}, 16'd1);
         check("halting_halted", {15'd0, halted}, 16'd0);
         @(posedge clk); #1;
      end
      stall = 1'b0;
      @(posedge clk); #1;
      check("halt_halted", {15'd0, halted}, 16'd1);
      check("halt_instr_valid", {15'd0, instr_valid}, 16'd0);

      reqs = 0;
      for (int k = 0; k < 20; k++) begin
         redirect = (k == 5);
         redirect_pc = 16'h0040;
         @(posedge clk); #1;
         if (imem_req) reqs++;
      end
      redirect = 1'b0;
      check("halted_req_count", 16'(reqs), 16'd0);
      check("halted_after_redirect", {15'd0, halted}, 16'd1);

      // Reset while halted; then a redirect during a 3-cycle WAIT.
      rst = 1'b1;
      @(posedge clk); #1;
      check("rst_halted_instr_valid", {15'd0, instr_valid}, 16'd0);
      check("rst_halted_halted", {15'd0, halted}, 16'd0);
      check("rst_halted_pc_out", pc_out, 16'h0000);
      aq.push_back(16'h0000); aq.push_back(16'h0002);
      aq.push_back(16'h0102); aq.push_back(16'h0104);
      iq.push_back(mk(16'h4000, 16'h0000, 16'h0002));
      iq.push_back(mk(16'h4102, 16'h0102, 16'h0104));
      lat = 3;
      rst = 1'b0;

      wait_req(16'h0002);
      @(posedge clk); #1;
      redirect = 1'b1;
      redirect_pc = 16'h0103;
      @(posedge clk); #1;
      redirect = 1'b0;
      wait_req(16'h0102);
      check("redirect_drop_valid", {15'd0, instr_valid}, 16'd0);

      // Reset while waiting on the 0x0104 response.
      wait_req(16'h0104);
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      check("rst_wait_instr_valid", {15'd0, instr_valid}, 16'd0);
      check("rst_wait_halted", {15'd0, halted}, 16'd0);
      check("rst_wait_req", {15'd0, imem_req}, 16'd0);
      aq.push_back(16'h0000);
      iq.push_back(mk(16'h4000, 16'h0000, 16'h0002));
      rst = 1'b0;
      wait_main_empty();
      rst = 1'b1;

      // PC wrap from RESET_PC = 0xFFFE.
      waq.push_back(16'hFFFE); waq.push_back(16'h0000);
      wiq.push_back(mk(16'h47FE, 16'hFFFE, 16'h0000));
      wiq.push_back(mk(16'h4000, 16'h0000, 16'h0002));
      w_rst = 1'b0;
      wait_wrap_empty();
      w_rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;

      check("final_aq_empty", 16'(aq.size()), 16'd0);
      check("final_iq_empty", 16'(iq.size()), 16'd0);
      check("final_waq_empty", 16'(waq.size()), 16'd0);
      check("final_wiq_empty", 16'(wiq.size()), 16'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
